// File: rtl/usb_epbuf_arb_pkg.sv
// usb_epbuf_arb_pkg
// Shared types for the EP buffer arbiter.
//   owner_e  : identifies which requester held the most recent grant.
//   rr_owner : round-robin preference given the last owner.
package usb_epbuf_arb_pkg;

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_e;

  // On a tie, the requester that was not granted last gets the grant.
  function automatic owner_e rr_owner(input owner_e last);
    return (last == OWN_R0) ? OWN_R1 : OWN_R0;
  endfunction

endpackage

// File: rtl/usb_epbuf_arb.sv
// usb_epbuf_arb
// Two-requester arbiter in front of a USB endpoint buffer. Requester 0 is
// the CPU, requester 1 the DMA engine. At most one access (a write to the
// TX port or a read from the RX port) is issued per cycle.
//
// Ports
//   clk, rst                     clock (EP buffer domain), async active-high reset
//   r0_* / r1_*                  request/write-not-read/address/data/mask (mask
//                                bit 1 = byte not written), ack, rvalid, rdata
//   r1_lock                      DMA burst-hold hint
//   ep_tx_addr_0/data_0/wmsk_0/we_0   TX buffer write port
//   ep_rx_addr_0/re_0, ep_rx_data_1   RX buffer read port, data one cycle later
//
// The grant is combinational; only the last-grant bit, the lock counter and
// the two rvalid flops are stored.
module usb_epbuf_arb
  import usb_epbuf_arb_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [MW-1:0] r0_wmsk,
  output logic          r0_ack,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [MW-1:0] r1_wmsk,
  input  logic          r1_lock,
  output logic          r1_ack,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,

  output logic [AW-1:0] ep_tx_addr_0,
  output logic [DW-1:0] ep_tx_data_0,
  output logic [MW-1:0] ep_tx_wmsk_0,
  output logic          ep_tx_we_0,
  output logic [AW-1:0] ep_rx_addr_0,
  output logic          ep_rx_re_0,
  input  logic [DW-1:0] ep_rx_data_1
);

  localparam int LOCK_MAX = 16;
  // The counter must be able to hold LOCK_MAX itself so that exactly
  // LOCK_MAX lock-won grants are allowed before r0 is forced through.
  localparam int LW = $clog2(LOCK_MAX) + 1;
  localparam logic [LW-1:0] LOCK_LIMIT = LW'(LOCK_MAX);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

  owner_e          last_q, last_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            r0_rvalid_q, r1_rvalid_q;

  logic            gnt0, gnt1, lock_won;

  // Grant decision. Reset gates everything so no strobe escapes while rst
  // is high, independent of the clock.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    lock_won = 1'b0;
    if (!rst) begin
      if (r0_req && r1_req) begin
        if (rr_owner(last_q) == OWN_R1) begin
          gnt1 = 1'b1;
        end else if (r1_lock && (lock_cnt_q != LOCK_LIMIT)) begin
          // r0 would win by round-robin; the lock keeps the bus with r1.
          gnt1     = 1'b1;
          lock_won = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt1) begin
      last_d = OWN_R1;
    end else if (gnt0) begin
      last_d = OWN_R0;
    end
  end

  // Consecutive lock count: any r0 grant or a cycle without the hint ends
  // the burst; only grants actually taken from a waiting r0 are counted.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (gnt0 || !r1_lock) begin
      lock_cnt_d = '0;
    end else if (lock_won) begin
      lock_cnt_d = lock_cnt_q + LOCK_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= OWN_R1;
      lock_cnt_q  <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      r0_rvalid_q <= gnt0 && !r0_we;
      r1_rvalid_q <= gnt1 && !r1_we;
    end
  end

  assign r0_ack = gnt0;
  assign r1_ack = gnt1;

  // Shared address/data path: the granted requester's fields go out;
  // with no grant the values are irrelevant because both strobes are low.
  assign ep_tx_addr_0 = gnt1 ? r1_addr  : r0_addr;
  assign ep_tx_data_0 = gnt1 ? r1_wdata : r0_wdata;
  assign ep_tx_wmsk_0 = gnt1 ? r1_wmsk  : r0_wmsk;
  assign ep_rx_addr_0 = gnt1 ? r1_addr  : r0_addr;
  assign ep_tx_we_0   = (gnt0 && r0_we)  || (gnt1 && r1_we);
  assign ep_rx_re_0   = (gnt0 && !r0_we) || (gnt1 && !r1_we);

  // Read data arrives from the buffer one cycle after the strobe; it is
  // steered to the owner and forced to zero elsewhere so the buses can be
  // OR-combined downstream.
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = {DW{r0_rvalid_q}} & ep_rx_data_1;
  assign r1_rdata  = {DW{r1_rvalid_q}} & ep_rx_data_1;

endmodule

// File: tb/tb_usb_epbuf_arb.sv
module tb_usb_epbuf_arb;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam logic [15:0] R1_WDATA = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r0_ack, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic [MW-1:0] r0_wmsk;
  logic          r1_req, r1_we, r1_lock, r1_ack, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [MW-1:0] r1_wmsk;
  logic [AW-1:0] ep_tx_addr_0, ep_rx_addr_0;
  logic [DW-1:0] ep_tx_data_0;
  logic [MW-1:0] ep_tx_wmsk_0;
  logic          ep_tx_we_0, ep_rx_re_0;
  logic [DW-1:0] ep_rx_data_1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_epbuf_arb #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wmsk(r0_wmsk), .r0_ack(r0_ack), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wmsk(r1_wmsk), .r1_lock(r1_lock), .r1_ack(r1_ack), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata),
    .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0), .ep_tx_wmsk_0(ep_tx_wmsk_0),
    .ep_tx_we_0(ep_tx_we_0), .ep_rx_addr_0(ep_rx_addr_0), .ep_rx_re_0(ep_rx_re_0),
    .ep_rx_data_1(ep_rx_data_1)
  );

  // Endpoint buffer model: byte-masked write, registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [15:0] ram_init(input logic [8:0] a);
    return {~a[7:0], a[7:0]};
  endfunction

  always @(posedge clk) begin
    if (ep_tx_we_0) begin
      if (!ep_tx_wmsk_0[0]) mem[ep_tx_addr_0][7:0]  <= ep_tx_data_0[7:0];
      if (!ep_tx_wmsk_0[1]) mem[ep_tx_addr_0][15:8] <= ep_tx_data_0[15:8];
    end
    if (ep_rx_re_0) ep_rx_data_1 <= mem[ep_rx_addr_0];
  end

  typedef struct {
    logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [8:0]  a0, a1;
    logic [15:0] wd0;
    logic [1:0]  wm0;
    logic        e_ack0, e_ack1, e_we, e_re;
    logic [8:0]  e_addr;
    logic        e_rv0, e_rv1;
    logic [15:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vecs[$];

  // rq = {r0_req, r0_we, r1_req, r1_we}; es = {ack0, ack1, we, re}; erv = {rv0, rv1}
  function automatic vec_t mk(input logic [3:0] rq, input logic [8:0] a0, input logic [8:0] a1,
                              input logic [15:0] wd0, input logic [1:0] wm0, input logic lock,
                              input logic [3:0] es, input logic [8:0] ea, input logic [1:0] erv,
                              input logic [15:0] erd0, input logic [15:0] erd1);
    vec_t v;
    v.r0_req = rq[3]; v.r0_we = rq[2]; v.r1_req = rq[1]; v.r1_we = rq[0];
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wm0 = wm0; v.r1_lock = lock;
    v.e_ack0 = es[3]; v.e_ack1 = es[2]; v.e_we = es[1]; v.e_re = es[0];
    v.e_addr = ea; v.e_rv0 = erv[1]; v.e_rv1 = erv[0]; v.e_rd0 = erd0; v.e_rd1 = erd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rq0, input logic we0, input logic [8:0] a0,
                       input logic [15:0] wd0, input logic [1:0] wm0,
                       input logic rq1, input logic we1, input logic [8:0] a1, input logic lock);
    r0_req = rq0; r0_we = we0; r0_addr = a0; r0_wdata = wd0; r0_wmsk = wm0;
    r1_req = rq1; r1_we = we1; r1_addr = a1; r1_wdata = R1_WDATA; r1_wmsk = 2'b00;
    r1_lock = lock;
  endtask

  initial begin
    vec_t v;
    logic exp1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = ram_init(9'(i));
    ep_rx_data_1 = '0;

    // Reset with both requesting: no ack, no strobe, no rvalid.
    rst = 1'b1;
    drive(1'b1, 1'b0, 9'h010, 16'h0, 2'b0, 1'b1, 1'b0, 9'h020, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ack0", 32'(r0_ack), 32'd0);
    chk("rst_ack1", 32'(r1_ack), 32'd0);
    chk("rst_re", 32'(ep_rx_re_0), 32'd0);
    chk("rst_we", 32'(ep_tx_we_0), 32'd0);
    chk("rst_rv", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 32'd0);
    $display("reset check done");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 9'h0, 16'h0, 2'b0, 1'b0, 1'b0, 9'h0, 1'b0);

    // Directed vector table.
    vecs.push_back(mk(4'b1010, 9'h010, 9'h020, 16'h0, 2'b00, 1'b0, 4'b1001, 9'h010, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b0010, 9'h000, 9'h020, 16'h0, 2'b00, 1'b0, 4'b0101, 9'h020, 2'b10, ram_init(9'h010), 16'h0));
    vecs.push_back(mk(4'b0000, 9'h000, 9'h000, 16'h0, 2'b00, 1'b0, 4'b0000, 9'h000, 2'b01, 16'h0, ram_init(9'h020)));
    vecs.push_back(mk(4'b1100, 9'h005, 9'h000, 16'h1234, 2'b10, 1'b0, 4'b1010, 9'h005, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1000, 9'h005, 9'h000, 16'h0, 2'b00, 1'b0, 4'b1001, 9'h005, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b0000, 9'h000, 9'h000, 16'h0, 2'b00, 1'b0, 4'b0000, 9'h000, 2'b10, 16'hFA34, 16'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(4'b0010, 9'h000, 9'(9'h030 + i), 16'h0, 2'b00, 1'b0, 4'b0101, 9'(9'h030 + i),
                        (i > 0) ? 2'b01 : 2'b00, 16'h0, (i > 0) ? ram_init(9'(9'h030 + i - 1)) : 16'h0));
    vecs.push_back(mk(4'b0000, 9'h000, 9'h000, 16'h0, 2'b00, 1'b0, 4'b0000, 9'h000, 2'b01, 16'h0, ram_init(9'h037)));
    // Alternating reads, no bubble.
    vecs.push_back(mk(4'b1010, 9'h040, 9'h050, 16'h0, 2'b00, 1'b0, 4'b1001, 9'h040, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1010, 9'h041, 9'h050, 16'h0, 2'b00, 1'b0, 4'b0101, 9'h050, 2'b10, ram_init(9'h040), 16'h0));
    vecs.push_back(mk(4'b1010, 9'h041, 9'h051, 16'h0, 2'b00, 1'b0, 4'b1001, 9'h041, 2'b01, 16'h0, ram_init(9'h050)));
    vecs.push_back(mk(4'b0010, 9'h000, 9'h051, 16'h0, 2'b00, 1'b0, 4'b0101, 9'h051, 2'b10, ram_init(9'h041), 16'h0));
    vecs.push_back(mk(4'b0000, 9'h000, 9'h000, 16'h0, 2'b00, 1'b0, 4'b0000, 9'h000, 2'b01, 16'h0, ram_init(9'h051)));
    // r1 write, then a lock-won r1 read over r0, then r0 reads the r1 write.
    vecs.push_back(mk(4'b0011, 9'h000, 9'h006, 16'h0, 2'b00, 1'b0, 4'b0110, 9'h006, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1010, 9'h006, 9'h007, 16'h0, 2'b00, 1'b1, 4'b0101, 9'h007, 2'b00, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1000, 9'h006, 9'h000, 16'h0, 2'b00, 1'b0, 4'b1001, 9'h006, 2'b01, 16'h0, ram_init(9'h007)));
    vecs.push_back(mk(4'b0000, 9'h000, 9'h000, 16'h0, 2'b00, 1'b0, 4'b0000, 9'h000, 2'b10, R1_WDATA, 16'h0));

    foreach (vecs[k]) begin
      v = vecs[k];
      @(posedge clk); #1;
      drive(v.r0_req, v.r0_we, v.a0, v.wd0, v.wm0, v.r1_req, v.r1_we, v.a1, v.r1_lock);
      @(negedge clk);
      chk($sformatf("v%0d_ack0", k), 32'(r0_ack), 32'(v.e_ack0));
      chk($sformatf("v%0d_ack1", k), 32'(r1_ack), 32'(v.e_ack1));
      chk($sformatf("v%0d_we", k), 32'(ep_tx_we_0), 32'(v.e_we));
      chk($sformatf("v%0d_re", k), 32'(ep_rx_re_0), 32'(v.e_re));
      chk($sformatf("v%0d_rv0", k), 32'(r0_rvalid), 32'(v.e_rv0));
      chk($sformatf("v%0d_rv1", k), 32'(r1_rvalid), 32'(v.e_rv1));
      chk($sformatf("v%0d_rd0", k), 32'(r0_rdata), 32'(v.e_rd0));
      chk($sformatf("v%0d_rd1", k), 32'(r1_rdata), 32'(v.e_rd1));
      if (v.e_re) chk($sformatf("v%0d_raddr", k), 32'(ep_rx_addr_0), 32'(v.e_addr));
      if (v.e_we) begin
        chk($sformatf("v%0d_waddr", k), 32'(ep_tx_addr_0), 32'(v.e_addr));
        chk($sformatf("v%0d_wdata", k), 32'(ep_tx_data_0), v.e_ack1 ? 32'(R1_WDATA) : 32'(v.wd0));
        chk($sformatf("v%0d_wmsk", k), 32'(ep_tx_wmsk_0), v.e_ack1 ? 32'd0 : 32'(v.wm0));
      end
      $display("vec %0d: ack0=%0b ack1=%0b we=%0b re=%0b rv0=%0b rv1=%0b rd0=%h rd1=%h",
               k, r0_ack, r1_ack, ep_tx_we_0, ep_rx_re_0, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
    end

    // Lock burst: last grant was r0. Cycle 0 r1 by round-robin, 1..16 lock-won,
    // 17 forced to r0, 18 r1 by round-robin, 19 lock-won again.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 9'h060, 16'h0, 2'b0, 1'b1, 1'b0, 9'h061, 1'b1);
      @(negedge clk);
      exp1 = (i != 17);
      chk($sformatf("lock%0d_ack1", i), 32'(r1_ack), 32'(exp1));
      chk($sformatf("lock%0d_ack0", i), 32'(r0_ack), 32'(!exp1));
      $display("lock cycle %0d: ack0=%0b ack1=%0b", i, r0_ack, r1_ack);
    end
    // Hint dropped: plain round-robin gives r0; hint back: r1 by round-robin.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 9'h060, 16'h0, 2'b0, 1'b1, 1'b0, 9'h061, 1'b0);
    @(negedge clk);
    chk("unlock_ack0", 32'(r0_ack), 32'd1);
    $display("unlock: ack0=%0b ack1=%0b", r0_ack, r1_ack);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 9'h060, 16'h0, 2'b0, 1'b1, 1'b0, 9'h061, 1'b1);
    @(negedge clk);
    chk("relock_ack1", 32'(r1_ack), 32'd1);
    $display("relock: ack0=%0b ack1=%0b", r0_ack, r1_ack);

    // Reset while an r0 read is in flight.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 9'h070, 16'h0, 2'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    @(negedge clk);
    chk("inflight_ack0", 32'(r0_ack), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 9'h0, 16'h0, 2'b0, 1'b1, 1'b0, 9'h071, 1'b0);
    @(negedge clk);
    chk("inflight_rv0", 32'(r0_rvalid), 32'd0);
    chk("inflight_rd0", 32'(r0_rdata), 32'd0);
    chk("inrst_ack1", 32'(r1_ack), 32'd0);
    chk("inrst_re", 32'(ep_rx_re_0), 32'd0);
    $display("reset in flight: rv0=%0b rd0=%h ack1=%0b re=%0b", r0_rvalid, r0_rdata, r1_ack, ep_rx_re_0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 9'h072, 16'h0, 2'b0, 1'b1, 1'b0, 9'h073, 1'b0);
    @(negedge clk);
    chk("post_rst_ack0", 32'(r0_ack), 32'd1);
    chk("post_rst_ack1", 32'(r1_ack), 32'd0);
    $display("post reset tie: ack0=%0b ack1=%0b", r0_ack, r1_ack);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 9'h0, 16'h0, 2'b0, 1'b0, 1'b0, 9'h0, 1'b0);
    @(negedge clk);
    chk("post_rst_rd0", 32'(r0_rdata), 32'(ram_init(9'h072)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
